imem_dmem_arbiter: RTL and testbench

- Sequences the single-port 32-bit word memory shared by three requesters:
  - the program loader port, which preloads code such as HALT = 32'hfc000000;
  - the pipeline IF stage (instruction fetch);
  - the pipeline MEM stage (load/store).
- Adds a load/run/halt mode state machine, fixed priority with an anti-starvation counter for fetch, and routes the one-cycle-latency read data back to the winner.
- Sits between pipe_MIPS32's stage logic and the memory array.

---
 rtl/mips_pkg.sv | 6 +
 rtl/arb_fairness_cnt.sv | 23 ++
 rtl/imem_dmem_arbiter.sv | 111 +++++++++++
 tb/tb_imem_dmem_arbiter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the pipe_MIPS32 memory arbiter.
package mips_pkg;
    typedef enum logic [1:0] {MODE_LOAD = 2'd0, MODE_RUN = 2'd1, MODE_HALT = 2'd2} mode_e;
    typedef enum logic [1:0] {TAG_NONE = 2'd0, TAG_IF = 2'd1, TAG_DM = 2'd2} rd_tag_e;
    localparam logic [5:0] OP_HALT = 6'h3f;
endpackage

// File: rtl/arb_fairness_cnt.sv
// arb_fairness_cnt: saturating count of denied fetch cycles; flags forced fetch priority.
module arb_fairness_cnt #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk1,
    input  logic rst_n,
    input  logic en_i,
    input  logic miss_i,
    input  logic hit_i,
    output logic force_o
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_WAIT);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = (!en_i || hit_i) ? '0 : (miss_i && cnt_q != MAX_C) ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign force_o = (cnt_q == MAX_C);
endmodule

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: load/run/halt sequencing of one single-port word memory
// shared by the program loader, the IF stage and the MEM stage.
module imem_dmem_arbiter
    import mips_pkg::*;
#(
    parameter int AW       = 10,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    input  logic          ld_done,
    output logic          ld_gnt,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic [DW-1:0] if_rdata,
    output logic          if_rvalid,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_rvalid,
    input  logic          halted,
    output logic          stall_if,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    mode
);
    mode_e         state_q, state_d;
    rd_tag_e       rd_tag_q, rd_tag_d;
    logic [DW-1:0] if_rdata_q, dm_rdata_q;
    logic          force_if;

    always_comb begin
        state_d = state_q;
        case (state_q)
            MODE_LOAD: state_d = ld_done ? MODE_RUN : MODE_LOAD;
            MODE_RUN:  state_d = halted ? MODE_HALT : MODE_RUN;
            MODE_HALT: state_d = ld_req ? MODE_LOAD : (!halted ? MODE_RUN : MODE_HALT);
            default:   state_d = MODE_LOAD;
        endcase
    end

    // Grants are masked while reset is held so nothing reaches the memory.
    always_comb begin
        ld_gnt = 1'b0;
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (rst_n) begin
            case (state_q)
                MODE_LOAD: ld_gnt = ld_req;
                MODE_RUN: begin
                    if_gnt = if_req & (force_if | ~dm_req);
                    dm_gnt = dm_req & ~if_gnt;
                end
                MODE_HALT: begin
                    ld_gnt = ld_req;
                    dm_gnt = dm_req & ~ld_req;
                end
                default: ;
            endcase
        end
    end

    assign mem_en    = ld_gnt | if_gnt | dm_gnt;
    assign mem_we    = ld_gnt ? ld_we : (dm_gnt ? dm_we : 1'b0);
    assign mem_addr  = ld_gnt ? ld_addr : if_gnt ? if_addr : dm_gnt ? dm_addr : '0;
    assign mem_wdata = ld_gnt ? ld_wdata : dm_gnt ? dm_wdata : '0;
    assign stall_if  = rst_n & if_req & ~if_gnt;
    assign mode      = state_q;

    // Loader reads are granted but never tagged, so they return nothing.
    assign rd_tag_d  = if_gnt ? TAG_IF : (dm_gnt && !dm_we) ? TAG_DM : TAG_NONE;
    assign if_rvalid = (rd_tag_q == TAG_IF);
    assign dm_rvalid = (rd_tag_q == TAG_DM);
    assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
    assign dm_rdata  = dm_rvalid ? mem_rdata : dm_rdata_q;

    arb_fairness_cnt #(.MAX_WAIT(MAX_WAIT)) u_fair (
        .clk1    (clk1),
        .rst_n   (rst_n),
        .en_i    (state_q == MODE_RUN && state_d == MODE_RUN),
        .miss_i  (if_req & ~if_gnt),
        .hit_i   (if_gnt),
        .force_o (force_if)
    );

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= MODE_LOAD;
            rd_tag_q   <= TAG_NONE;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            rd_tag_q   <= rd_tag_d;
            if_rdata_q <= if_rdata;
            dm_rdata_q <= dm_rdata;
        end
    end
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb_imem_dmem_arbiter: directed checks of mode sequencing, arbitration and read return.
module tb_imem_dmem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    logic clk1 = 1'b0, rst_n = 1'b0;
    logic ld_req = 0, ld_we = 0, ld_done = 0, if_req = 0, dm_req = 0, dm_we = 0, halted = 0;
    logic [AW-1:0] ld_addr = '0, if_addr = '0, dm_addr = '0;
    logic [DW-1:0] ld_wdata = '0, dm_wdata = '0, mem_rdata = '0;
    logic ld_gnt, if_gnt, if_rvalid, dm_gnt, dm_rvalid, stall_if, mem_en, mem_we;
    logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [1:0] mode;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] prog [0:8];
    int total = 0, bad = 0;

    imem_dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
        .clk1(clk1), .rst_n(rst_n),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_done(ld_done), .ld_gnt(ld_gnt),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata),
        .if_rvalid(if_rvalid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rdata(dm_rdata), .dm_rvalid(dm_rvalid),
        .halted(halted), .stall_if(stall_if),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mode(mode)
    );

    always #5 clk1 = ~clk1;

    always @(posedge clk1) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk1);
        #1;
    endtask

    initial begin
        prog[0] = 32'h2801000a; prog[1] = 32'h28020014; prog[2] = 32'h28030019;
        prog[3] = 32'h0ce77800; prog[4] = 32'h00222000; prog[5] = 32'h0ce77800;
        prog[6] = 32'h00832800; prog[7] = 32'h0ce77800; prog[8] = 32'hfc000000;
        ld_req = 1; if_req = 1;
        #2;
        chk("rst_mode", {30'd0, mode}, 32'd0);
        chk("rst_ld_gnt", {31'd0, ld_gnt}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_stall", {31'd0, stall_if}, 32'd0);
        chk("rst_rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
        chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
        tick;
        rst_n = 1;
        for (int i = 0; i < 9; i++) begin
            ld_req = 1; ld_we = 1; ld_addr = AW'(i); ld_wdata = prog[i]; ld_done = (i == 8);
            #1;
            chk("ld_gnt", {31'd0, ld_gnt}, 32'd1);
            chk("ld_mem_we", {30'd0, mem_en, mem_we}, 32'd3);
            chk("ld_mem_addr", {22'd0, mem_addr}, i);
            chk("ld_mem_wdata", mem_wdata, prog[i]);
            chk("ld_if_gnt", {31'd0, if_gnt}, 32'd0);
            chk("ld_stall", {31'd0, stall_if}, 32'd1);
            chk("ld_mode", {30'd0, mode}, 32'd0);
            tick;
        end
        ld_req = 0; ld_we = 0; ld_done = 0;
        if_req = 1; if_addr = 0;
        #1;
        chk("run_mode", {30'd0, mode}, 32'd1);
        chk("f0_gnt", {31'd0, if_gnt}, 32'd1);
        chk("f0_mem", {21'd0, mem_we, mem_addr}, 32'd0);
        chk("f0_rvalid", {31'd0, if_rvalid}, 32'd0);
        for (int i = 1; i < 4; i++) begin
            tick;
            if_req = (i < 3); if_addr = AW'(i);
            #1;
            chk("fetch_rvalid", {31'd0, if_rvalid}, 32'd1);
            chk("fetch_rdata", if_rdata, prog[i-1]);
        end
        tick;
        #1;
        chk("fetch_idle_rvalid", {31'd0, if_rvalid}, 32'd0);
        chk("fetch_hold_rdata", if_rdata, 32'h28030019);
        for (int k = 1; k <= 6; k++) begin
            if_req = 1; if_addr = 5; dm_req = 1; dm_we = 1; dm_addr = AW'(100 + k); dm_wdata = 32'(k);
            #1;
            chk("arb_dm_gnt", {31'd0, dm_gnt}, {31'd0, k != 5});
            chk("arb_if_gnt", {31'd0, if_gnt}, {31'd0, k == 5});
            chk("arb_stall", {31'd0, stall_if}, {31'd0, k != 5});
            tick;
        end
        dm_we = 0; dm_addr = 8; if_addr = 2;
        #1;
        chk("dmrd_gnt", {30'd0, dm_gnt, if_gnt}, 32'd2);
        chk("dmrd_mem", {21'd0, mem_we, mem_addr}, 32'd8);
        tick;
        dm_req = 0; if_req = 0;
        #1;
        chk("dmrd_rvalid", {30'd0, dm_rvalid, if_rvalid}, 32'd2);
        chk("dmrd_rdata", dm_rdata, 32'hfc000000);
        tick;
        halted = 1; if_req = 1; if_addr = 3;
        #1;
        chk("h1_mode", {30'd0, mode}, 32'd1);
        chk("h1_if_gnt", {31'd0, if_gnt}, 32'd1);
        tick;
        dm_req = 1; dm_we = 0; dm_addr = 0;
        #1;
        chk("h2_mode", {30'd0, mode}, 32'd2);
        chk("h2_grants", {30'd0, if_gnt, dm_gnt}, 32'd1);
        chk("h2_stall", {31'd0, stall_if}, 32'd1);
        chk("h2_if_rdata", if_rdata, prog[3]);
        tick;
        if_req = 0; dm_req = 0; ld_req = 1; ld_we = 1; ld_addr = 9; ld_wdata = 32'h12345678;
        #1;
        chk("h3_dm_rdata", dm_rdata, prog[0]);
        chk("h3_dm_rvalid", {31'd0, dm_rvalid}, 32'd1);
        chk("h3_ld_gnt", {31'd0, ld_gnt}, 32'd1);
        chk("h3_mode", {30'd0, mode}, 32'd2);
        tick;
        ld_req = 0; halted = 0; ld_done = 1;
        #1;
        chk("reload_mode", {30'd0, mode}, 32'd0);
        tick;
        ld_done = 0; if_req = 1; if_addr = 1;
        #1;
        chk("rerun_mode", {30'd0, mode}, 32'd1);
        chk("rerun_if_gnt", {31'd0, if_gnt}, 32'd1);
        tick;
        chk("pend_rvalid", {31'd0, if_rvalid}, 32'd1);
        rst_n = 0;
        #1;
        chk("mid_rst_rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
        chk("mid_rst_mode", {30'd0, mode}, 32'd0);
        chk("mid_rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("mid_rst_gnt", {29'd0, ld_gnt, if_gnt, dm_gnt}, 32'd0);
        chk("mid_rst_rdata", if_rdata, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
